// File: rtl/ddr3_pg_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_pg_rr_arbiter
// Purpose  : Round-robin arbiter granting one of four page-transfer requesters
//            access to a shared DDR3 page transfer engine, with ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_pg_rr_arbiter #(
    parameter int          N_PORTS        = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_PORTS-1:0]        port_pg_req,
    input  logic [N_PORTS-1:0]        port_pg_optype,
    input  logic [N_PORTS-1:0][27:0]  port_pg_req_addr,
    input  logic [N_PORTS-1:0][127:0] port_dpram_dout,
    input  logic [N_PORTS-1:0]        port_en,
    output logic [N_PORTS-1:0]        port_pg_ack,
    output logic [N_PORTS-1:0]        port_dpram_wren,
    output logic                      ddr3_pg_req,
    output logic                      ddr3_pg_optype,
    output logic [27:0]               ddr3_pg_req_addr,
    output logic [127:0]              ddr3_dpram_dout,
    input  logic                      ddr3_pg_ack,
    input  logic                      ddr3_dpram_wren,
    output logic [1:0]                cur_idx,
    output logic                      busy,
    output logic                      timeout_pulse,
    output logic                      timeout_sticky,
    input  logic                      timeout_clr
);

    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        S_REQ_WAIT   = 2'd0,
        S_PG_REQ     = 2'd1,
        S_CLEAR_WAIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [N_PORTS-1:0]   req_meta_q;
    logic [N_PORTS-1:0]   req_s_q;
    logic [IDX_W-1:0]     cur_idx_q, cur_idx_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 pg_req_q, pg_req_d;
    logic                 aborted_q, aborted_d;
    logic [N_PORTS-1:0]   ack_q, ack_d;
    logic                 tmo_pulse_q, tmo_d;
    logic                 tmo_sticky_q, tmo_sticky_d;

    logic                 busy_w;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;

    assign busy_w = (state_q != S_REQ_WAIT);

    // Request levels come from other clock domains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_meta_q <= '0;
            req_s_q    <= '0;
        end else begin
            req_meta_q <= port_pg_req;
            req_s_q    <= req_meta_q;
        end
    end

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        cand      = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            cand = rr_ptr_q + IDX_W'(k);
            if (req_s_q[cand] && port_en[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_idx_d = cur_idx_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        pg_req_d  = pg_req_q;
        aborted_d = aborted_q;
        tmo_d     = 1'b0;
        case (state_q)
            S_REQ_WAIT: begin
                pg_req_d = 1'b0;
                if (win_found) begin
                    cur_idx_d = win_idx;
                    pg_req_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_PG_REQ;
                end
            end
            S_PG_REQ: begin
                pg_req_d = 1'b1;
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
                // Ack takes priority over a coincident timeout.
                if (ddr3_pg_ack) begin
                    state_d = S_CLEAR_WAIT;
                end else if (cnt_q == TIMEOUT_CYCLES - 16'd1) begin
                    pg_req_d  = 1'b0;
                    tmo_d     = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = S_CLEAR_WAIT;
                end
            end
            S_CLEAR_WAIT: begin
                pg_req_d = req_s_q[cur_idx_q] && !aborted_q;
                if (!req_s_q[cur_idx_q] && !pg_req_q && !ddr3_pg_ack) begin
                    pg_req_d  = 1'b0;
                    rr_ptr_d  = cur_idx_q + IDX_W'(1);
                    aborted_d = 1'b0;
                    state_d   = S_REQ_WAIT;
                end
            end
            default: begin
                pg_req_d  = 1'b0;
                aborted_d = 1'b0;
                state_d   = S_REQ_WAIT;
            end
        endcase
    end

    always_comb begin
        ack_d = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            ack_d[i] = ddr3_pg_ack && (cur_idx_q == IDX_W'(i)) && busy_w;
        end
    end

    // A new timeout overrides a simultaneous clear.
    assign tmo_sticky_d = tmo_d ? 1'b1 : (timeout_clr ? 1'b0 : tmo_sticky_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ_WAIT;
            cur_idx_q    <= '0;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            pg_req_q     <= 1'b0;
            aborted_q    <= 1'b0;
            ack_q        <= '0;
            tmo_pulse_q  <= 1'b0;
            tmo_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_idx_q    <= cur_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            pg_req_q     <= pg_req_d;
            aborted_q    <= aborted_d;
            ack_q        <= ack_d;
            tmo_pulse_q  <= tmo_d;
            tmo_sticky_q <= tmo_sticky_d;
        end
    end

    always_comb begin
        port_dpram_wren = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            port_dpram_wren[i] = ddr3_dpram_wren && (cur_idx_q == IDX_W'(i)) && busy_w;
        end
    end

    assign ddr3_pg_optype   = port_pg_optype[cur_idx_q];
    assign ddr3_pg_req_addr = port_pg_req_addr[cur_idx_q];
    assign ddr3_dpram_dout  = port_dpram_dout[cur_idx_q];

    assign port_pg_ack    = ack_q;
    assign ddr3_pg_req    = pg_req_q;
    assign cur_idx        = cur_idx_q;
    assign busy           = busy_w;
    assign timeout_pulse  = tmo_pulse_q;
    assign timeout_sticky = tmo_sticky_q;

endmodule
`default_nettype wire

// File: doc/ddr3_pg_rr_arbiter.md
DDR3_PG_RR_ARBITER -- requirements
Module: ddr3_pg_rr_arbiter

Interface
REQ-001 The block SHALL have parameter N_PORTS, default 4, number of page-transfer requesters (fixed at 4 in this revision).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, the maximum number of cycles to wait for ddr3_pg_ack in S_PG_REQ.
REQ-003 The block SHALL have port clk, input, 1 bit: DDR3 ui clock; all logic is in this single clock domain.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port port_pg_req, input, 4 bits: per-port page request levels, asynchronous to clk.
REQ-006 The block SHALL have port port_pg_optype, input, 4 bits: per-port optype.
REQ-007 The block SHALL have port port_pg_req_addr, input, 4x28 bits: per-port page addresses.
REQ-008 The block SHALL have port port_dpram_dout, input, 4x128 bits: per-port DPRAM read data.
REQ-009 The block SHALL have port port_en, input, 4 bits: arbitration enable mask.
REQ-010 The block SHALL have port port_pg_ack, output, 4 bits: registered per-port ack.
REQ-011 The block SHALL have port port_dpram_wren, output, 4 bits: combinational per-port write enable.
REQ-012 The block SHALL have port ddr3_pg_req, output, 1 bit: registered request to the DDR3 page transfer engine.
REQ-013 The block SHALL have ports ddr3_pg_optype (1 bit), ddr3_pg_req_addr (28 bits) and ddr3_dpram_dout (128 bits), all outputs: the muxed fields of the selected port.
REQ-014 The block SHALL have ports ddr3_pg_ack and ddr3_dpram_wren, inputs, 1 bit each, from the engine.
REQ-015 The block SHALL have port cur_idx, output, 2 bits: the selected port.
REQ-016 The block SHALL have port busy, output, 1 bit: high when the FSM is not in S_REQ_WAIT.
REQ-017 The block SHALL have port timeout_pulse, output, 1 bit: one-cycle pulse on timeout.
REQ-018 The block SHALL have port timeout_sticky, output, 1 bit: latched timeout flag.
REQ-019 The block SHALL have port timeout_clr, input, 1 bit: clears timeout_sticky.

Function
REQ-020 Each port_pg_req bit SHALL pass through a 2-flop synchronizer (req_s[i]) before use, giving 2 cycles of latency.
REQ-021 ddr3_pg_optype, ddr3_pg_req_addr and ddr3_dpram_dout SHALL be combinationally muxed from port cur_idx in every state.
REQ-022 port_dpram_wren[i] SHALL equal ddr3_dpram_wren && cur_idx==i && busy.
REQ-023 port_pg_ack[i] SHALL be registered as ddr3_pg_ack && cur_idx==i && busy.
REQ-024 The FSM SHALL have states S_REQ_WAIT, S_PG_REQ and S_CLEAR_WAIT; any other encoding SHALL go to S_REQ_WAIT.
REQ-025 In S_REQ_WAIT, the block SHALL scan ports rr_ptr, rr_ptr+1, ... (mod 4) and pick the first i with req_s[i] && port_en[i].
- On a winner: cur_idx<=i, ddr3_pg_req<=1, go to S_PG_REQ; request-to-ddr3_pg_req latency is 1 cycle after req_s.
- With no winner: hold state and cur_idx.
REQ-026 In S_PG_REQ, the block SHALL hold ddr3_pg_req=1 and increment the 16-bit wait counter.
- On ddr3_pg_ack: go to S_CLEAR_WAIT.
- Else, when the counter reaches TIMEOUT_CYCLES-1: ddr3_pg_req<=0, pulse timeout_pulse, set timeout_sticky, set the aborted flag, go to S_CLEAR_WAIT.
REQ-027 ddr3_pg_ack and timeout SHALL NOT both take effect in the same cycle; if they coincide, ack wins and no timeout is flagged.
REQ-028 In S_CLEAR_WAIT, ddr3_pg_req SHALL follow req_s[cur_idx], or be forced 0 if aborted.
- Exit when !req_s[cur_idx] && !ddr3_pg_req && !ddr3_pg_ack.
- On exit: rr_ptr<=cur_idx+1 (mod 4), clear aborted, go to S_REQ_WAIT.
REQ-029 Deasserting port_en[cur_idx] mid-transaction SHALL NOT abort the transaction; it only affects the next scan.
REQ-030 The wait counter SHALL clear on entry to S_PG_REQ and SHALL NOT wrap.
REQ-031 timeout_clr SHALL clear timeout_sticky; if timeout_clr and a new timeout occur in the same cycle, set wins.

Reset
REQ-032 While rst is high, the block SHALL asynchronously force: FSM=S_REQ_WAIT, cur_idx=0, rr_ptr=0, synchronizers=0, counter=0, ddr3_pg_req=0, port_pg_ack=0, timeout_pulse=0, timeout_sticky=0, aborted=0.
REQ-033 Reset asserted mid-transaction SHALL drop ddr3_pg_req immediately, with no ack forwarded afterwards.

Verification
REQ-034 Single request: raise port_pg_req[2] with ack after 5 cycles -> ddr3_pg_req rises 3 cycles after the req edge; port_pg_ack[2] is 1 cycle after ddr3_pg_ack; the other acks stay 0; rr_ptr becomes 3.
REQ-035 All four ports requesting continuously -> grants in order 0,1,2,3,0; each port receives exactly one ack per rotation.
REQ-036 port_en=4'b1011 with all ports requesting -> port 2 is never granted; the order is 0,1,3,0.
REQ-037 TIMEOUT_CYCLES=16 with no ack -> ddr3_pg_req drops after 16 cycles in S_PG_REQ; timeout_pulse is high for 1 cycle; timeout_sticky=1 until timeout_clr.
REQ-038 Ack arriving in the same cycle the counter reaches 15 -> normal completion; timeout_sticky stays 0.
REQ-039 rst asserted during S_PG_REQ on port 1 -> all outputs reach reset values without waiting for a clk edge; after release, arbitration restarts at port 0.
